// File: rtl/riscv_pkg.sv
// Shared widths and requester identity for the register-file writeback path.
// No logic; constants and types only.
// No flow control.
package riscv_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between the ALU and LSU writeback requesters.
// Grants are combinational from the valids; pointer updates on the clock edge.
// The pointer moves only on contested cycles, to the side that just lost.
module rr_arb2
    import riscv_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic alu_vld,
    input  logic lsu_vld,
    output logic alu_gnt,
    output logic lsu_gnt
);

    req_e prio_q;
    req_e prio_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= REQ_LSU;
        end else begin
            prio_q <= prio_nxt;
        end
    end

    always_comb begin
        prio_nxt = prio_q;
        if (alu_vld && lsu_vld) begin
            prio_nxt = (prio_q == REQ_LSU) ? REQ_ALU : REQ_LSU;
        end
    end

    always_comb begin
        alu_gnt = alu_vld && (!lsu_vld || (prio_q == REQ_ALU));
        lsu_gnt = lsu_vld && (!alu_vld || (prio_q == REQ_LSU));
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback arbiter plus pending-write scoreboard for hazard detection.
// One-cycle latency from accepted transfer to registered write port.
// Ready is combinational; the losing requester is held off until its turn.
module regfile_wb_ctrl
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                       Clk,
    input  logic                       ResetN,
    input  logic                       AluValid,
    output logic                       AluReady,
    input  logic [ADDR_WIDTH-1:0]      AluAddr,
    input  logic [DATA_WIDTH-1:0]      AluData,
    input  logic                       LsuValid,
    output logic                       LsuReady,
    input  logic [ADDR_WIDTH-1:0]      LsuAddr,
    input  logic [DATA_WIDTH-1:0]      LsuData,
    output logic                       WrEn,
    output logic [ADDR_WIDTH-1:0]      WrAddr,
    output logic [DATA_WIDTH-1:0]      WrData,
    input  logic                       IssueValid,
    input  logic [ADDR_WIDTH-1:0]      IssueAddr,
    input  logic [ADDR_WIDTH-1:0]      RdAddr1,
    input  logic [ADDR_WIDTH-1:0]      RdAddr2,
    output logic                       Hazard1,
    output logic                       Hazard2,
    output logic [2**ADDR_WIDTH-1:0]   Busy
);

    localparam int NREG = 2**ADDR_WIDTH;

    logic                  alu_gnt;
    logic                  lsu_gnt;
    logic                  xfer;
    logic                  wr_commit;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NREG-1:0]       busy_q;
    logic [NREG-1:0]       busy_nxt;

    rr_arb2 u_arb (
        .clk     (Clk),
        .rst_n   (ResetN),
        .alu_vld (AluValid),
        .lsu_vld (LsuValid),
        .alu_gnt (alu_gnt),
        .lsu_gnt (lsu_gnt)
    );

    // Readies are masked while reset is held so nothing handshakes into a clearing pipeline.
    assign AluReady = alu_gnt & ResetN;
    assign LsuReady = lsu_gnt & ResetN;

    always_comb begin
        xfer      = AluReady | LsuReady;
        sel_addr  = LsuReady ? LsuAddr : AluAddr;
        sel_data  = LsuReady ? LsuData : AluData;
        wr_commit = xfer && (sel_addr != '0);
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            WrEn   <= 1'b0;
            WrAddr <= '0;
            WrData <= '0;
        end else begin
            WrEn <= wr_commit;
            if (wr_commit) begin
                WrAddr <= sel_addr;
                WrData <= sel_data;
            end
        end
    end

    // Issue is applied after commit so a same-cycle set/clear on one register stays set.
    always_comb begin
        busy_nxt = busy_q;
        if (WrEn) begin
            busy_nxt[WrAddr] = 1'b0;
        end
        if (IssueValid) begin
            busy_nxt[IssueAddr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign Busy    = busy_q;
    assign Hazard1 = busy_q[RdAddr1];
    assign Hazard2 = busy_q[RdAddr2];

endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have port Clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port ResetN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports AluValid input 1, AluReady output 1, AluAddr input ADDR_WIDTH, AluData input DATA_WIDTH: ALU writeback requester.
REQ-006 SHALL have ports LsuValid input 1, LsuReady output 1, LsuAddr input ADDR_WIDTH, LsuData input DATA_WIDTH: load-unit writeback requester.
REQ-007 SHALL have ports WrEn output 1, WrAddr output ADDR_WIDTH, WrData output DATA_WIDTH: registered drive of the register file write port.
REQ-008 SHALL have ports IssueValid input 1, IssueAddr input ADDR_WIDTH: destination reservation from issue stage.
REQ-009 SHALL have ports RdAddr1, RdAddr2 input ADDR_WIDTH; Hazard1, Hazard2 output 1: read-operand hazard flags.
REQ-010 SHALL have port Busy output 2**ADDR_WIDTH: per-register pending-write vector.

Function
REQ-011 Handshake SHALL be valid/ready; transfer occurs in a cycle with Valid and Ready both high; requester holds Valid, Addr, Data stable until transfer.
REQ-012 Ready SHALL be combinational: single valid requester always granted; both valid -> requester selected by round-robin pointer granted, other Ready low.
REQ-013 Round-robin pointer SHALL update only on contested cycles (both valid), pointing to the loser for the next contest; uncontested grants leave it unchanged.
REQ-014 Accepted transfer SHALL appear on WrAddr/WrData next cycle with WrEn high (1-cycle latency); no transfer -> WrEn low next cycle, WrAddr/WrData hold last value.
REQ-015 Transfer with Addr = 0 SHALL be accepted (Ready high) but produce WrEn low; x0 never written.
REQ-016 Busy[i] SHALL set on posedge when IssueValid and IssueAddr = i, i != 0.
REQ-017 Busy[i] SHALL clear on posedge when WrEn and WrAddr = i in the preceding cycle (write committed).
REQ-018 Simultaneous set and clear of the same bit SHALL resolve to set.
REQ-019 Busy[0] SHALL be constant 0.
REQ-020 HazardN SHALL equal Busy[RdAddrN], combinational; RdAddrN = 0 -> 0.
REQ-021 IssueValid to an already-busy register SHALL leave Busy set; bench assertion flags it as an issue-stage WAW error.

Reset
REQ-022 ResetN low SHALL asynchronously force WrEn 0, WrAddr 0, WrData 0, Busy all 0, pointer to LSU priority.
REQ-023 Reset mid-transfer SHALL discard the pending write; no WrEn after deassertion until a new transfer.
REQ-024 During reset AluReady and LsuReady SHALL be 0.

Structure
REQ-025 ADDR_WIDTH/DATA_WIDTH defaults and a requester enum (REQ_ALU, REQ_LSU) SHALL live in shared package riscv_pkg.
REQ-026 Two-way round-robin arbitration SHALL be a sub-module rr_arb2 (valids in, grants out, pointer state inside); scoreboard and output register stay in regfile_wb_ctrl.

Verification
REQ-027 After reset, LsuValid only, LsuAddr=5, LsuData=0xDEADBEEF -> LsuReady=1 same cycle; next cycle WrEn=1, WrAddr=5, WrData=0xDEADBEEF.
REQ-028 AluValid and LsuValid held high 4 cycles, distinct addrs 1/2 -> grants alternate LSU, ALU, LSU, ALU; WrAddr sequence 2,1,2,1.
REQ-029 AluValid, AluAddr=0, AluData=0x1234 -> AluReady=1, next cycle WrEn=0.
REQ-030 IssueValid IssueAddr=7, then RdAddr1=7 -> Hazard1=1; ALU write to 7 -> Hazard1 falls cycle after WrEn; IssueValid addr 7 in clear cycle -> Busy[7] stays 1.
REQ-031 ALU transfer accepted, ResetN pulsed low before next posedge -> WrEn=0, Busy=0, no write after release.
